// File: rtl/mem_pkg.sv
// Shared types and defaults for the MEM stage controller.
// Exports DEF_XLEN, DEF_TIMEOUT_CYCLES and the mem_state_t FSM encoding.
package mem_pkg;

   localparam int DEF_XLEN           = 64;
   localparam int DEF_TIMEOUT_CYCLES = 255;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with load and bubble controls.
// Ports: clk, reset, i_load (1=load, 0=bubble), i_* MEM-side fields, o_* WB-side fields.
module mem_wb_reg
   import mem_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_load,
   input  logic [XLEN-1:0] i_rdata,
   input  logic [XLEN-1:0] i_alu,
   input  logic [4:0]      i_rd,
   input  logic            i_memtoreg,
   input  logic            i_regwrite,
   output logic [XLEN-1:0] o_rdata,
   output logic [XLEN-1:0] o_alu,
   output logic [4:0]      o_rd,
   output logic            o_memtoreg,
   output logic            o_regwrite
);

   logic [XLEN-1:0] r_rdata;
   logic [XLEN-1:0] r_alu;
   logic [4:0]      r_rd;
   logic            r_memtoreg;
   logic            r_regwrite;

   // Bubble clears only the write-enable style controls; data fields hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdata    <= '0;
         r_alu      <= '0;
         r_rd       <= '0;
         r_memtoreg <= 1'b0;
         r_regwrite <= 1'b0;
      end else if (i_load) begin
         r_rdata    <= i_rdata;
         r_alu      <= i_alu;
         r_rd       <= i_rd;
         r_memtoreg <= i_memtoreg;
         r_regwrite <= i_regwrite;
      end else begin
         r_memtoreg <= 1'b0;
         r_regwrite <= 1'b0;
      end
   end

   assign o_rdata    = r_rdata;
   assign o_alu      = r_alu;
   assign o_rd       = r_rd;
   assign o_memtoreg = r_memtoreg;
   assign o_regwrite = r_regwrite;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues dmem valid/ready requests, stalls upstream, feeds MEM/WB.
// Ports: MEM_* from EX/MEM, dmem_req_*/dmem_resp_*, mem_stall, mem_pcsrc, mem_err, WB_*.
// Optional macro MEM_TIMEOUT_EN adds TIMEOUT_CYCLES abort with a mem_err pulse.
module mem_stage_ctrl
   import mem_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
`ifdef MEM_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] MEM_PC,
   input  logic [XLEN-1:0] MEM_ALUResult,
   input  logic [XLEN-1:0] MEM_ReadData2,
   input  logic [4:0]      MEM_Rd,
   input  logic            MEM_MemtoReg,
   input  logic            MEM_RegWrite,
   input  logic            MEM_MemRead,
   input  logic            MEM_MemWrite,
   input  logic            MEM_Branch,
   input  logic            MEM_Zero,
   output logic            dmem_req_valid,
   output logic            dmem_req_we,
   output logic [XLEN-1:0] dmem_req_addr,
   output logic [XLEN-1:0] dmem_req_wdata,
   input  logic            dmem_req_ready,
   input  logic            dmem_resp_valid,
   input  logic [XLEN-1:0] dmem_resp_rdata,
   output logic            mem_stall,
   output logic            mem_pcsrc,
   output logic            mem_err,
   output logic [XLEN-1:0] WB_ReadData,
   output logic [XLEN-1:0] WB_ALUResult,
   output logic [4:0]      WB_Rd,
   output logic            WB_MemtoReg,
   output logic            WB_RegWrite
);

   mem_state_t      r_state;
   logic            r_req_valid;
   logic            r_we;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_wdata;
   logic [XLEN-1:0] r_rdata;

   logic            w_memop;
   logic            w_tmo;
   logic            w_done;
   logic [XLEN-1:0] w_wb_rdata;
   logic            w_wb_regwrite;
   logic            w_unused;

   // The PC travels with the instruction but nothing in this stage needs it.
   assign w_unused = ^MEM_PC;

   assign w_memop = MEM_MemRead | MEM_MemWrite;
   assign w_done  = (r_state == DONE);

`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] r_cnt;
   logic          r_tmo;
   logic          r_err;
   logic          w_tmo_hit;

   // Last REQ/WAIT cycle: the counter reaches TIMEOUT_CYCLES at this edge.
   assign w_tmo_hit = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign w_tmo     = r_tmo;
   assign mem_err   = r_err;
`else
   assign w_tmo     = 1'b0;
   assign mem_err   = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_req_valid <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
`ifdef MEM_TIMEOUT_EN
         r_cnt       <= '0;
         r_tmo       <= 1'b0;
         r_err       <= 1'b0;
`endif
      end else begin
`ifdef MEM_TIMEOUT_EN
         r_err <= 1'b0;
         if (r_state == REQ || r_state == WAIT) begin
            r_cnt <= r_cnt + CW'(1);
         end
`endif
         unique case (r_state)
            IDLE: begin
               if (w_memop) begin
                  r_addr      <= MEM_ALUResult;
                  r_wdata     <= MEM_ReadData2;
                  r_we        <= MEM_MemWrite;
                  r_rdata     <= '0;
                  r_req_valid <= 1'b1;
                  r_state     <= REQ;
`ifdef MEM_TIMEOUT_EN
                  r_cnt       <= '0;
                  r_tmo       <= 1'b0;
`endif
               end
            end
            REQ: begin
`ifdef MEM_TIMEOUT_EN
               if (w_tmo_hit) begin
                  r_req_valid <= 1'b0;
                  r_tmo       <= 1'b1;
                  r_err       <= 1'b1;
                  r_state     <= DONE;
               end else
`endif
               if (dmem_req_ready) begin
                  r_req_valid <= 1'b0;
                  // Writes are posted; only reads wait for a response.
                  r_state     <= r_we ? DONE : WAIT;
               end
            end
            WAIT: begin
`ifdef MEM_TIMEOUT_EN
               if (w_tmo_hit) begin
                  r_tmo   <= 1'b1;
                  r_err   <= 1'b1;
                  r_state <= DONE;
               end else
`endif
               if (dmem_resp_valid) begin
                  r_rdata <= dmem_resp_rdata;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign dmem_req_valid = r_req_valid;
   assign dmem_req_we    = r_we;
   assign dmem_req_addr  = r_addr;
   assign dmem_req_wdata = r_wdata;

   assign mem_stall = ~reset & (((r_state == IDLE) & w_memop)
                               | (r_state == REQ)
                               | (r_state == WAIT));

   assign mem_pcsrc = MEM_Branch & MEM_Zero;

   // Read data reaches WB only for a completed, non-aborted load.
   assign w_wb_rdata    = (w_done & ~r_we & ~w_tmo) ? r_rdata : '0;
   assign w_wb_regwrite = MEM_RegWrite & ~(w_done & w_tmo);

   mem_wb_reg #(
      .XLEN (XLEN)
   ) u_mem_wb_reg (
      .clk        (clk),
      .reset      (reset),
      .i_load     (~mem_stall),
      .i_rdata    (w_wb_rdata),
      .i_alu      (MEM_ALUResult),
      .i_rd       (MEM_Rd),
      .i_memtoreg (MEM_MemtoReg),
      .i_regwrite (w_wb_regwrite),
      .o_rdata    (WB_ReadData),
      .o_alu      (WB_ALUResult),
      .o_rd       (WB_Rd),
      .o_memtoreg (WB_MemtoReg),
      .o_regwrite (WB_RegWrite)
   );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl.
// Timeout scenario is exercised only when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic [XLEN-1:0] MEM_PC;
   logic [XLEN-1:0] MEM_ALUResult;
   logic [XLEN-1:0] MEM_ReadData2;
   logic [4:0]      MEM_Rd;
   logic            MEM_MemtoReg;
   logic            MEM_RegWrite;
   logic            MEM_MemRead;
   logic            MEM_MemWrite;
   logic            MEM_Branch;
   logic            MEM_Zero;
   logic            dmem_req_valid;
   logic            dmem_req_we;
   logic [XLEN-1:0] dmem_req_addr;
   logic [XLEN-1:0] dmem_req_wdata;
   logic            dmem_req_ready;
   logic            dmem_resp_valid;
   logic [XLEN-1:0] dmem_resp_rdata;
   logic            mem_stall;
   logic            mem_pcsrc;
   logic            mem_err;
   logic [XLEN-1:0] WB_ReadData;
   logic [XLEN-1:0] WB_ALUResult;
   logic [4:0]      WB_Rd;
   logic            WB_MemtoReg;
   logic            WB_RegWrite;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage_ctrl #(
      .XLEN           (XLEN)
`ifdef MEM_TIMEOUT_EN
      , .TIMEOUT_CYCLES (8)
`endif
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .MEM_PC          (MEM_PC),
      .MEM_ALUResult   (MEM_ALUResult),
      .MEM_ReadData2   (MEM_ReadData2),
      .MEM_Rd          (MEM_Rd),
      .MEM_MemtoReg    (MEM_MemtoReg),
      .MEM_RegWrite    (MEM_RegWrite),
      .MEM_MemRead     (MEM_MemRead),
      .MEM_MemWrite    (MEM_MemWrite),
      .MEM_Branch      (MEM_Branch),
      .MEM_Zero        (MEM_Zero),
      .dmem_req_valid  (dmem_req_valid),
      .dmem_req_we     (dmem_req_we),
      .dmem_req_addr   (dmem_req_addr),
      .dmem_req_wdata  (dmem_req_wdata),
      .dmem_req_ready  (dmem_req_ready),
      .dmem_resp_valid (dmem_resp_valid),
      .dmem_resp_rdata (dmem_resp_rdata),
      .mem_stall       (mem_stall),
      .mem_pcsrc       (mem_pcsrc),
      .mem_err         (mem_err),
      .WB_ReadData     (WB_ReadData),
      .WB_ALUResult    (WB_ALUResult),
      .WB_Rd           (WB_Rd),
      .WB_MemtoReg     (WB_MemtoReg),
      .WB_RegWrite     (WB_RegWrite)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic rd, input logic wr, input logic m2r,
                         input logic rw, input logic [4:0] rdst,
                         input logic [63:0] alu, input logic [63:0] d2);
      MEM_MemRead   = rd;
      MEM_MemWrite  = wr;
      MEM_MemtoReg  = m2r;
      MEM_RegWrite  = rw;
      MEM_Rd        = rdst;
      MEM_ALUResult = alu;
      MEM_ReadData2 = d2;
   endtask

   initial begin
      reset           = 1'b1;
      MEM_PC          = 64'h1000;
      MEM_Branch      = 1'b0;
      MEM_Zero        = 1'b0;
      dmem_req_ready  = 1'b0;
      dmem_resp_valid = 1'b0;
      dmem_resp_rdata = '0;
      set_op(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0);
      #2;
      chk("rst_stall_forced0", mem_stall, 0);
      chk("rst_req_valid", dmem_req_valid, 0);
      chk("rst_req_addr", dmem_req_addr, 0);
      chk("rst_wb_regwrite", WB_RegWrite, 0);
      chk("rst_wb_alu", WB_ALUResult, 0);
      chk("rst_mem_err", mem_err, 0);
      MEM_MemRead = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // ALU op passes through in one cycle
      set_op(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 64'h1234, 64'h0);
      #1;
      chk("alu_stall", mem_stall, 0);
      tick();
      chk("alu_stall_after", mem_stall, 0);
      chk("alu_wb_alu", WB_ALUResult, 64'h1234);
      chk("alu_wb_rd", WB_Rd, 5);
      chk("alu_wb_regwrite", WB_RegWrite, 1);
      chk("alu_wb_rdata", WB_ReadData, 0);

      // Branch decision is combinational
      MEM_Branch = 1'b1;
      MEM_Zero   = 1'b1;
      #1;
      chk("pcsrc_taken", mem_pcsrc, 1);
      MEM_Zero = 1'b0;
      #1;
      chk("pcsrc_not_taken", mem_pcsrc, 0);
      MEM_Branch = 1'b0;

      // Load, ready immediately, response next cycle
      set_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 64'h100, 64'h0);
      dmem_req_ready = 1'b1;
      #1;
      chk("ld_idle_stall", mem_stall, 1);
      chk("ld_idle_valid", dmem_req_valid, 0);
      tick();
      chk("ld_req_valid", dmem_req_valid, 1);
      chk("ld_req_addr", dmem_req_addr, 64'h100);
      chk("ld_req_we", dmem_req_we, 0);
      chk("ld_req_stall", mem_stall, 1);
      chk("ld_bubble_regwrite", WB_RegWrite, 0);
      tick();
      chk("ld_wait_valid", dmem_req_valid, 0);
      chk("ld_wait_stall", mem_stall, 1);
      dmem_req_ready  = 1'b0;
      dmem_resp_valid = 1'b1;
      dmem_resp_rdata = 64'hDEADBEEF;
      tick();
      dmem_resp_valid = 1'b0;
      chk("ld_done_stall", mem_stall, 0);
      tick();
      chk("ld_wb_rdata", WB_ReadData, 64'hDEADBEEF);
      chk("ld_wb_memtoreg", WB_MemtoReg, 1);
      chk("ld_wb_regwrite", WB_RegWrite, 1);
      chk("ld_wb_rd", WB_Rd, 7);

      // Store held for 3 cycles before acceptance; stray response ignored
      set_op(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h200, 64'h55);
      dmem_resp_valid = 1'b1;
      dmem_resp_rdata = 64'hBAD0;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("st_valid", dmem_req_valid, 1);
         chk("st_addr", dmem_req_addr, 64'h200);
         chk("st_wdata", dmem_req_wdata, 64'h55);
         chk("st_we", dmem_req_we, 1);
         chk("st_stall", mem_stall, 1);
         chk("st_bubble_regwrite", WB_RegWrite, 0);
         tick();
      end
      dmem_resp_valid = 1'b0;
      chk("st_valid_4th", dmem_req_valid, 1);
      chk("st_addr_4th", dmem_req_addr, 64'h200);
      dmem_req_ready = 1'b1;
      tick();
      dmem_req_ready = 1'b0;
      chk("st_done_valid", dmem_req_valid, 0);
      chk("st_done_stall", mem_stall, 0);
      tick();
      chk("st_wb_alu", WB_ALUResult, 64'h200);
      chk("st_wb_rdata", WB_ReadData, 0);
      chk("st_wb_regwrite", WB_RegWrite, 0);

      // Read and write both set behaves as a posted write
      set_op(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'h280, 64'h77);
      dmem_req_ready = 1'b1;
      tick();
      chk("rw_we", dmem_req_we, 1);
      chk("rw_wdata", dmem_req_wdata, 64'h77);
      tick();
      chk("rw_done_stall", mem_stall, 0);
      dmem_req_ready = 1'b0;
      tick();
      chk("rw_wb_alu", WB_ALUResult, 64'h280);

      // Reset while waiting for a read response
      set_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 64'h300, 64'h0);
      dmem_req_ready = 1'b1;
      tick();
      tick();
      dmem_req_ready = 1'b0;
      chk("rw_wait_stall", mem_stall, 1);
      reset = 1'b1;
      #1;
      chk("rstw_valid", dmem_req_valid, 0);
      chk("rstw_stall", mem_stall, 0);
      chk("rstw_wb_alu", WB_ALUResult, 0);
      chk("rstw_wb_rd", WB_Rd, 0);
      set_op(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0);
      tick();
      reset = 1'b0;
      dmem_resp_valid = 1'b1;
      dmem_resp_rdata = 64'hCAFE;
      tick();
      dmem_resp_valid = 1'b0;
      chk("late_stall", mem_stall, 0);
      chk("late_valid", dmem_req_valid, 0);
      chk("late_wb_rdata", WB_ReadData, 0);
      chk("late_wb_regwrite", WB_RegWrite, 0);
      chk("late_wb_memtoreg", WB_MemtoReg, 0);

`ifdef MEM_TIMEOUT_EN
      // Memory never accepts: abort after 8 REQ cycles
      set_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 64'h400, 64'h0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("to_stall", mem_stall, 1);
         chk("to_err_low", mem_err, 0);
      end
      tick();
      chk("to_err_pulse", mem_err, 1);
      chk("to_valid_drop", dmem_req_valid, 0);
      chk("to_stall_release", mem_stall, 0);
      tick();
      chk("to_err_clear", mem_err, 0);
      chk("to_wb_regwrite", WB_RegWrite, 0);
      chk("to_wb_rdata", WB_ReadData, 0);
      set_op(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
